square_input_conditioner: RTL and testbench
===========================================

# square_input_conditioner

Front-end conditioner for the tic-tac-toe board buttons. It synchronizes and debounces the nine square buttons and the erase/restart/random buttons. It turns each accepted press into a single-cycle pulse on `cuadro[8:0]`, `erase`, `restart` and `randomClick`, which are wired directly into the game FSM inputs of the same names. It also enforces one-square-at-a-time, so the game FSM never sees a multi-square press.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- `CNT_W`, default 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk_100MHz`  in  1  single system clock, 100 MHz; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `btn_cuadro`  in  9  raw asynchronous square buttons, 1 = pressed; bit i = square i.
- `btn_erase`  in  1  raw erase button.
- `btn_restart`  in  1  raw restart button.
- `btn_random`  in  1  raw random-move button.
- `cuadro`  out  9  one-cycle press pulse; at most one bit set in any cycle.
- `erase`  out  1  one-cycle press pulse.
- `restart`  out  1  one-cycle press pulse.
- `randomClick`  out  1  one-cycle press pulse.
- `sq_state`  out  2  square arbiter state for debug: 0 IDLE, 1 HELD, 2 BLOCKED.

## Operation
- **Per-line conditioning (12 lines, identical):**
  - 2-flop synchronizer, producing `sync`.
  - Debounced level register `stab` and counter `cnt`.
  - `sync == stab` → `cnt` cleared.
  - Otherwise `cnt` increments. When it reaches DEBOUNCE_CYCLES−1 while still differing, `stab` takes `sync` and `cnt` clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `stab`.
- **Press event:** rising edge of `stab` (registered previous value 0, current value 1). Releases produce no pulse.
- **Control buttons:** each press event on erase/restart/random drives the corresponding output to 1 for exactly one cycle. The three are independent; simultaneous pulses are allowed.
- **Square arbiter FSM** (`nsq` = number of set bits in `stab_cuadro`):
  - IDLE:
    - Exactly one square press event and `nsq == 1` → pulse that `cuadro` bit, go to HELD.
    - `nsq >= 2` → go to BLOCKED, no pulse.
  - HELD:
    - No `cuadro` pulse, whatever other squares do.
    - `nsq == 0` → go to IDLE.
  - BLOCKED:
    - No pulse.
    - `nsq == 0` → go to IDLE.
  - Two squares reaching `stab` = 1 in the same cycle → BLOCKED, no pulse.
- **Control priority:** if an erase or restart pulse occurs in the same cycle as a square pulse would, the square pulse is suppressed. The FSM still moves to HELD, so that press is consumed.

## Timing
- **Reset (`reset` = 0):** asynchronously clears all synchronizer flops, `stab`, previous-`stab`, `cnt`, and all outputs to 0. `sq_state` = IDLE.
- **Latency:** a clean raw press, stable from the clock edge that first samples it, produces its output pulse DEBOUNCE_CYCLES+3 cycles later:
  - 2 cycles synchronizer.
  - DEBOUNCE_CYCLES cycles to update `stab`.
  - 1 cycle registered edge/output.
- **Outputs:** all registered. Pulse width is exactly 1 cycle however long the button is held.
- **Reset released while a button is held:** `stab` restarts at 0, so the held button yields one pulse DEBOUNCE_CYCLES+3 cycles after reset deassertion.
- **Reset mid-debounce:** partial count discarded; no pulse.
- **Counter bound:** `cnt` never exceeds DEBOUNCE_CYCLES−1 and never wraps.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4, CNT_W=3.
- **Reset values:** hold `reset`=0 with all buttons pressed → all outputs 0, `sq_state`=0. Release reset → `cuadro`=9'h1FF never appears; `sq_state` goes to 2 (BLOCKED) and no pulse occurs.
- **Clean single press:** `btn_cuadro[3]`=1 for 50 cycles → `cuadro`=9'h008 for exactly one cycle, 7 cycles after the first sampling edge; `sq_state` 1 until release, then 0.
- **Glitch rejection:** `btn_cuadro[7]`=1 for 3 cycles, then 0 → no pulse; `sq_state` stays 0.
- **Lockout:** hold square 4, then press square 8 while holding 4 → exactly one pulse, `cuadro`=9'h010. After releasing 4 while 8 is still held, no pulse for 8 until both are released and 8 is pressed again.
- **Simultaneous squares:** `btn_cuadro`=9'h021 in the same cycle → BLOCKED, zero `cuadro` pulses; after release, pressing square 5 alone → `cuadro`=9'h020.
- **Control buttons and priority:**
  - Press `btn_erase`, `btn_restart` and `btn_random` together → `erase`, `restart` and `randomClick` each pulse once, in the same cycle.
  - Press `btn_restart` and `btn_cuadro[0]` on the same edge → `restart` pulses, `cuadro` stays 0, `sq_state`=1.

Source files
------------

// File: rtl/square_input_conditioner.sv
// Button front end for the tic-tac-toe board: synchronizes and debounces twelve
// raw buttons, emits one-cycle press pulses and arbitrates one square at a time.

module square_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stab,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             stab_p2;
    logic             stab_prev;

    // synchronizer: two flops against metastability on the raw input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // debounce: level accepted only after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            stab_p2 <= 1'b0;
        end else if (sync_p1 == stab_p2) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stab_p2 <= sync_p1;
            cnt     <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // edge detect: previous debounced level for rising-edge recognition
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stab_prev <= 1'b0;
        end else begin
            stab_prev <= stab_p2;
        end
    end

    assign stab  = stab_p2;
    assign press = stab_p2 & ~stab_prev;

endmodule

module square_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [8:0] btn_cuadro,
    input  logic       btn_erase,
    input  logic       btn_restart,
    input  logic       btn_random,
    output logic [8:0] cuadro,
    output logic       erase,
    output logic       restart,
    output logic       randomClick,
    output logic [1:0] sq_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        BLOCKED = 2'd2
    } sq_state_t;

    function automatic logic [3:0] count_ones(input logic [8:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // bits 8:0 squares, 9 erase, 10 restart, 11 random
    logic [11:0] raw;
    logic [11:0] stab;
    logic [11:0] press;

    assign raw = {btn_random, btn_restart, btn_erase, btn_cuadro};

    for (genvar g = 0; g < 12; g++) begin : g_line
        square_input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_line (
            .clk  (clk_100MHz),
            .reset(reset),
            .raw  (raw[g]),
            .stab (stab[g]),
            .press(press[g])
        );
    end

    sq_state_t  state;
    sq_state_t  state_next;
    logic [8:0] sq_pulse;
    logic [3:0] nsq;
    logic [3:0] nev;
    logic       ctrl_prio;

    assign nsq       = count_ones(stab[8:0]);
    assign nev       = count_ones(press[8:0]);
    assign ctrl_prio = press[9] | press[10];

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // a square press claimed during an erase/restart is still consumed (HELD)
    always_comb begin
        state_next = state;
        sq_pulse   = '0;
        case (state)
            IDLE: begin
                if (nev == 4'd1 && nsq == 4'd1) begin
                    state_next = HELD;
                    if (!ctrl_prio) begin
                        sq_pulse = press[8:0];
                    end
                end else if (nsq >= 4'd2) begin
                    state_next = BLOCKED;
                end
            end
            HELD, BLOCKED: begin
                if (nsq == 4'd0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // output stage: every pulse leaves from a flop
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            cuadro      <= '0;
            erase       <= 1'b0;
            restart     <= 1'b0;
            randomClick <= 1'b0;
        end else begin
            cuadro      <= sq_pulse;
            erase       <= press[9];
            restart     <= press[10];
            randomClick <= press[11];
        end
    end

    assign sq_state = state;

endmodule

// File: tb/tb_square_input_conditioner.sv
// Scoreboard bench for square_input_conditioner: a window-based debounce model
// predicts every cycle's outputs; directed scenarios plus random button traffic.

module tb_square_input_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] btn_cuadro;
    logic       btn_erase;
    logic       btn_restart;
    logic       btn_random;
    logic [8:0] cuadro;
    logic       erase;
    logic       restart;
    logic       randomClick;
    logic [1:0] sq_state;

    square_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .btn_cuadro (btn_cuadro),
        .btn_erase  (btn_erase),
        .btn_restart(btn_restart),
        .btn_random (btn_random),
        .cuadro     (cuadro),
        .erase      (erase),
        .restart    (restart),
        .randomClick(randomClick),
        .sq_state   (sq_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [13:0] exp_q[$];

    int n_sq, last_sq_bit, last_sq_cyc;
    int n_er, n_rs, n_rd, er_cyc, rs_cyc, rd_cyc;
    int max_state;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic set_btn(input logic [11:0] v);
        {btn_random, btn_restart, btn_erase, btn_cuadro} = v;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_track();
        n_sq = 0; last_sq_bit = -1; last_sq_cyc = -1;
        n_er = 0; n_rs = 0; n_rd = 0;
        er_cyc = -1; rs_cyc = -1; rd_cyc = -1;
        max_state = 0;
    endtask

    // Reference: a line's level flips once the synchronized input has differed
    // from it over the last D cycles; pulses come one cycle after the flip.
    task automatic model_loop();
        logic [11:0] stab_m, raw_prev, ev, nstab, raw_now;
        logic [11:0] s_win[$];
        logic [8:0]  sqp;
        int          nsq, st;
        bit          flip;
        stab_m = '0; raw_prev = '0; ev = '0; nsq = 0; st = 0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                stab_m = '0; raw_prev = '0; ev = '0; nsq = 0; st = 0;
                s_win.delete();
                for (int k = 0; k < D; k++) s_win.push_back(12'h000);
                exp_q.push_back(14'h0000);
            end else begin
                raw_now = {btn_random, btn_restart, btn_erase, btn_cuadro};
                sqp = '0;
                if (st == 0) begin
                    if ($countones(ev[8:0]) == 1 && nsq == 1) begin
                        st = 1;
                        if (!(ev[9] || ev[10])) sqp = ev[8:0];
                    end else if (nsq >= 2) begin
                        st = 2;
                    end
                end else if (nsq == 0) begin
                    st = 0;
                end
                exp_q.push_back({sqp, ev[9], ev[10], ev[11], 2'(st)});
                nstab = stab_m;
                for (int i = 0; i < 12; i++) begin
                    flip = 1'b1;
                    foreach (s_win[k]) if (s_win[k][i] == stab_m[i]) flip = 1'b0;
                    if (flip) nstab[i] = ~stab_m[i];
                end
                ev     = nstab & ~stab_m;
                nsq    = $countones(nstab[8:0]);
                stab_m = nstab;
                s_win.push_back(raw_prev);
                if (s_win.size() > D) void'(s_win.pop_front());
                raw_prev = raw_now;
            end
        end
    endtask

    task automatic monitor_loop();
        logic [13:0] exp_r, act_r;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_r = exp_q.pop_front();
                act_r = {cuadro, erase, restart, randomClick, sq_state};
                chk(act_r == exp_r, "outputs", int'(act_r), int'(exp_r));
                chk($countones(cuadro) <= 1, "cuadro_onehot", int'(cuadro), 0);
                if (cuadro != 9'h000) begin
                    n_sq++;
                    last_sq_cyc = cyc;
                    for (int i = 0; i < 9; i++) if (cuadro[i]) last_sq_bit = i;
                end
                if (erase)       begin n_er++; er_cyc = cyc; end
                if (restart)     begin n_rs++; rs_cyc = cyc; end
                if (randomClick) begin n_rd++; rd_cyc = cyc; end
                if (int'(sq_state) > max_state) max_state = int'(sq_state);
            end
        end
    endtask

    initial begin
        int t0, r, hold;
        logic [11:0] v;
        reset = 1'b0;
        set_btn(12'hFFF);
        clear_track();
        fork
            model_loop();
            monitor_loop();
        join_none

        // reset held with every button pressed
        wait_cyc(5);
        chk(cuadro == 9'h000 && !erase && !restart && !randomClick, "reset_outputs",
            int'({cuadro, erase, restart, randomClick}), 0);
        chk(sq_state == 2'd0, "reset_state", int'(sq_state), 0);
        reset = 1'b1;
        wait_cyc(20);
        chk(n_sq == 0, "reset_release_no_square", n_sq, 0);
        chk(sq_state == 2'd2, "reset_release_blocked", int'(sq_state), 2);
        set_btn(12'h000);
        wait_cyc(20);

        // clean single press on square 3
        clear_track();
        set_btn(12'h008);
        t0 = cyc;
        wait_cyc(50);
        chk(sq_state == 2'd1, "single_held", int'(sq_state), 1);
        set_btn(12'h000);
        wait_cyc(20);
        chk(n_sq == 1 && last_sq_bit == 3, "single_pulse", n_sq * 16 + last_sq_bit, 16 + 3);
        chk(last_sq_cyc - t0 == D + 3, "single_latency", last_sq_cyc - t0, D + 3);
        chk(sq_state == 2'd0, "single_idle", int'(sq_state), 0);

        // glitch on square 7
        clear_track();
        set_btn(12'h080);
        wait_cyc(3);
        set_btn(12'h000);
        wait_cyc(20);
        chk(n_sq == 0, "glitch_no_pulse", n_sq, 0);
        chk(max_state == 0, "glitch_state", max_state, 0);

        // lockout: 4 held, 8 pressed on top
        clear_track();
        set_btn(12'h010); wait_cyc(15);
        set_btn(12'h110); wait_cyc(15);
        set_btn(12'h100); wait_cyc(15);
        chk(n_sq == 1 && last_sq_bit == 4, "lockout_first", n_sq * 16 + last_sq_bit, 16 + 4);
        set_btn(12'h000); wait_cyc(15);
        set_btn(12'h100); wait_cyc(15);
        set_btn(12'h000); wait_cyc(15);
        chk(n_sq == 2 && last_sq_bit == 8, "lockout_repress", n_sq * 16 + last_sq_bit, 32 + 8);

        // two squares on the same edge
        clear_track();
        set_btn(12'h021); wait_cyc(15);
        chk(sq_state == 2'd2, "simul_blocked", int'(sq_state), 2);
        set_btn(12'h000); wait_cyc(15);
        chk(n_sq == 0, "simul_no_pulse", n_sq, 0);
        set_btn(12'h020); wait_cyc(15);
        set_btn(12'h000); wait_cyc(15);
        chk(n_sq == 1 && last_sq_bit == 5, "simul_then_5", n_sq * 16 + last_sq_bit, 16 + 5);

        // three control buttons together
        clear_track();
        set_btn(12'hE00); wait_cyc(15);
        set_btn(12'h000); wait_cyc(15);
        chk(n_er == 1 && n_rs == 1 && n_rd == 1, "ctrl_counts", n_er * 256 + n_rs * 16 + n_rd, 273);
        chk(er_cyc == rs_cyc && rs_cyc == rd_cyc, "ctrl_same_cycle", er_cyc - rd_cyc, 0);

        // restart wins over square 0
        clear_track();
        set_btn(12'h401); wait_cyc(15);
        chk(n_rs == 1 && n_sq == 0, "prio_pulses", n_rs * 16 + n_sq, 16);
        chk(sq_state == 2'd1, "prio_held", int'(sq_state), 1);
        set_btn(12'h000); wait_cyc(15);

        // random traffic with occasional resets
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            v = '0;
            if (r >= 4 && r <= 6) v[$urandom_range(0, 8)] = 1'b1;
            else if (r == 7) begin
                v[$urandom_range(0, 8)] = 1'b1;
                v[$urandom_range(0, 8)] = 1'b1;
            end else if (r == 8) v[11:9] = 3'($urandom_range(0, 7));
            else if (r == 9) v = 12'($urandom);
            set_btn(v);
            hold = $urandom_range(1, 9);
            wait_cyc(hold);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                wait_cyc($urandom_range(1, 3));
                reset = 1'b1;
            end
        end
        set_btn(12'h000);
        wait_cyc(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
